ext_trigger_generator_mc: RTL and testbench
===========================================

// Module: ext_trigger_generator_mc
// PURPOSE
//  Multi-channel external trigger flag generator with programmable holdoff.
//  Each of NCH async external trigger inputs is synchronised and rising-edge detected.
//  Each accepted edge produces a one-cycle trigger pulse, then holdoff_i micro_ce_i ticks of dead time.
//  Sits between the external trigger pins and the trigger/readout logic; replaces the fixed 16-tick single-channel generator.
// PARAMETERS
//  NCH           4   number of independent trigger channels (1..16)
//  HOLDOFF_BITS  8   width of holdoff_i and of each channel's holdoff counter (2..16)
//  SYNC_STAGES   2   synchroniser flops per channel before edge detect (2..4)
// PORTS
//  clk_i       in   1             system clock; everything is clocked on its rising edge
//  rst_n_i     in   1             synchronous reset, active low
//  micro_ce_i  in   1             one-cycle clock enable (microsecond tick); holdoff time base
//  trig_i      in   NCH           async external trigger levels, one per channel
//  enable_i    in   NCH           per-channel accept enable; level, static or quasi-static
//  holdoff_i   in   HOLDOFF_BITS  holdoff length in micro_ce_i ticks, shared by all channels
//  trig_o      out  NCH           one-cycle trigger pulse per channel
//  trig_any_o  out  1             registered OR of trig_o, coincident with it
//  busy_o      out  NCH           channel is in FIRE or HOLD
//  reject_o    out  NCH           one-cycle pulse: an edge was detected but dropped because the channel was busy
// BEHAVIOUR
//  Reset (rst_n_i=0 at a clk_i edge):
//   - clears all sync flops, edge-history flops, counters and FSMs.
//   - every output = 0, FSM = IDLE.
//   - a trig_i held high across reset release is seen as one rising edge (sync chain restarts at 0).
//  Synchroniser / edge detect:
//   - per channel, trig_i passes through SYNC_STAGES flops, then one history flop.
//   - flag = last_sync & ~history (combinational, one cycle wide).
//  Per-channel FSM, all transitions registered:
//   IDLE: flag & enable_i -> FIRE.
//         flag & ~enable_i -> IDLE, silently ignored (no reject_o).
//   FIRE: lasts exactly one cycle; trig_o=1 while in FIRE.
//         cnt <= holdoff_i (sampled here only) -> HOLD; if holdoff_i==0 -> IDLE.
//   HOLD: micro_ce_i -> cnt <= cnt-1; micro_ce_i & cnt==1 -> IDLE.
//         A micro_ce_i coincident with the FIRE cycle does not count.
//  Timing:
//   - latency: trig_i first sampled high at edge E -> trig_o high in the cycle after edge E+SYNC_STAGES+1.
//   - dead time: exactly holdoff_i micro_ce_i ticks after FIRE.
//   - an edge detected in the clk_i cycle right after HOLD exits is accepted.
//  Outputs:
//   - busy_o = (state!=IDLE), registered with the state.
//   - reject_o = flag & busy in the same cycle; it never alters cnt (except as noted under CONFIGURATION).
//   - trig_any_o = |trig_o, computed from next-state so it is coincident with trig_o.
//  Boundary conditions:
//   - holdoff_i changing during HOLD: no effect until the next FIRE.
//   - enable_i dropping during FIRE/HOLD: holdoff completes normally; enable_i only gates acceptance in IDLE.
//   - cnt is unsigned; no wrap, never decremented at 0.
//   - channels are fully independent; simultaneous edges on several channels fire together.
//   - reset asserted mid-HOLD: channel returns to IDLE at the next edge.
// CONFIGURATION
//  EXT_TRIG_RETRIGGER_EN defined:
//   - in HOLD, flag & enable_i reloads cnt <= holdoff_i, so dead time extends from the last edge.
//   - no trig_o for that edge; reject_o still pulses.
//  EXT_TRIG_RETRIGGER_EN undefined:
//   - edges in FIRE/HOLD only pulse reject_o; dead time is fixed from the accepted edge.
//  Ports and latency are identical in both builds.
// TESTING (NCH=4, HOLDOFF_BITS=8, SYNC_STAGES=2, micro_ce_i every 10 clks unless noted)
//  1 Reset: hold rst_n_i=0 10 clks with trig_i=4'hF -> all outputs 0. Release -> trig_o=4'hF once, 4 edges later.
//  2 Latency/holdoff: holdoff_i=3, ch0 edge -> one trig_o[0] pulse at +4 edges.
//    busy_o[0] falls after the 3rd micro_ce_i following FIRE; edge 1 clk later -> accepted.
//  3 Reject: holdoff_i=5, ch1 edges at t=0 and t=20 clks -> one trig_o[1], one reject_o[1].
//    busy ends 5 ticks after FIRE; with EXT_TRIG_RETRIGGER_EN, 5 ticks after the second edge.
//  4 Zero holdoff: holdoff_i=0, edges on ch2 every 3 clks -> trig_o[2] for each edge, no reject_o.
//  5 Enable/independence: enable_i=4'b0101, simultaneous edges on all channels
//    -> trig_o=4'b0101, trig_any_o=1 same cycle, no reject_o.
//  6 Mid-op reset/config: change holdoff_i 2->9 during HOLD -> ends after 2 ticks.
//    Assert rst_n_i mid-HOLD -> busy_o=0 next edge.

Source files
------------

// File: rtl/ext_trigger_generator_mc.sv
// Multi-channel external trigger generator: sync + edge detect, one-cycle fire, micro_ce-timed holdoff.
// Optional build macro EXT_TRIG_RETRIGGER_EN: edges during HOLD restart the holdoff count.
module ext_trigger_generator_mc #(
    parameter int unsigned NCH          = 4,
    parameter int unsigned HOLDOFF_BITS = 8,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    micro_ce_i,
    input  logic [NCH-1:0]          trig_i,
    input  logic [NCH-1:0]          enable_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    output logic [NCH-1:0]          trig_o,
    output logic                    trig_any_o,
    output logic [NCH-1:0]          busy_o,
    output logic [NCH-1:0]          reject_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [HOLDOFF_BITS-1:0] CNT_ONE = HOLDOFF_BITS'(1);

    logic [NCH-1:0]          sync_q [SYNC_STAGES];
    logic [NCH-1:0]          sync_d [SYNC_STAGES];
    logic [NCH-1:0]          hist_q, hist_d;
    logic [NCH-1:0]          edge_q, edge_d;
    logic [NCH-1:0]          flag;
    logic [NCH-1:0]          retrig;
    logic [NCH-1:0]          busy;
    state_e                  state_q [NCH];
    state_e                  state_d [NCH];
    logic [HOLDOFF_BITS-1:0] cnt_q [NCH];
    logic [HOLDOFF_BITS-1:0] cnt_d [NCH];
    logic [NCH-1:0]          trig_q, trig_d;
    logic                    trig_any_q, trig_any_d;

    // Detected edges are registered once more so trig_o lands SYNC_STAGES+1 edges after first sample.
    always_comb begin
        sync_d[0] = trig_i;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        hist_d = sync_q[SYNC_STAGES-1];
        flag   = sync_q[SYNC_STAGES-1] & ~hist_q;
        edge_d = flag;
    end

    always_comb begin
`ifdef EXT_TRIG_RETRIGGER_EN
        retrig = edge_q & enable_i;
`else
        retrig = '0;
`endif
    end

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            busy[c]    = (state_q[c] != ST_IDLE);
            case (state_q[c])
                ST_IDLE: begin
                    if (edge_q[c] && enable_i[c]) begin
                        state_d[c] = ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    cnt_d[c]   = holdoff_i;
                    state_d[c] = (holdoff_i == '0) ? ST_IDLE : ST_HOLD;
                end
                ST_HOLD: begin
                    // A reload wins over a coincident tick so the dead time restarts in full.
                    if (retrig[c]) begin
                        cnt_d[c] = holdoff_i;
                        if (holdoff_i == '0) begin
                            state_d[c] = ST_IDLE;
                        end
                    end else if (micro_ce_i && (cnt_q[c] != '0)) begin
                        cnt_d[c] = cnt_q[c] - CNT_ONE;
                        if (cnt_q[c] == CNT_ONE) begin
                            state_d[c] = ST_IDLE;
                        end
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase
            trig_d[c] = (state_d[c] == ST_FIRE);
        end
        trig_any_d = |trig_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q     <= '0;
            edge_q     <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                state_q[c] <= ST_IDLE;
                cnt_q[c]   <= '0;
            end
            trig_q     <= '0;
            trig_any_q <= 1'b0;
        end else begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            hist_q     <= hist_d;
            edge_q     <= edge_d;
            for (int unsigned c = 0; c < NCH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            trig_q     <= trig_d;
            trig_any_q <= trig_any_d;
        end
    end

    assign trig_o     = trig_q;
    assign trig_any_o = trig_any_q;
    assign busy_o     = busy;
    assign reject_o   = edge_q & busy;

endmodule

// File: tb/tb_ext_trigger_generator_mc.sv
// Scoreboard bench for ext_trigger_generator_mc; expected trig_o pulses are queued when edges are driven.
module tb_ext_trigger_generator_mc;

    logic       clk = 1'b0;
    logic       rst_n_i;
    logic       micro_ce_i;
    logic [3:0] trig_i;
    logic [3:0] enable_i;
    logic [7:0] holdoff_i;
    logic [3:0] trig_o;
    logic       trig_any_o;
    logic [3:0] busy_o;
    logic [3:0] reject_o;

    ext_trigger_generator_mc #(
        .NCH          (4),
        .HOLDOFF_BITS (8),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n_i),
        .micro_ce_i (micro_ce_i),
        .trig_i     (trig_i),
        .enable_i   (enable_i),
        .holdoff_i  (holdoff_i),
        .trig_o     (trig_o),
        .trig_any_o (trig_any_o),
        .busy_o     (busy_o),
        .reject_o   (reject_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        logic [3:0]  mask;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned rej_seen [4] = '{default: 0};

    // Advance one clock; drive the tick, tally rejects and consume due scoreboard entries.
    task automatic advance();
        exp_t e;
        @(posedge clk);
        #1;
        micro_ce_i = (cyc % 10 == 0);
        for (int i = 0; i < 4; i++) rej_seen[i] += int'(reject_o[i]);
        if (exp_q.size() != 0 && exp_q[0].at == cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (trig_o !== e.mask) begin
                n_fail++;
                $display("FAIL trig_o @%0d: got %b expected %b", cyc, trig_o, e.mask);
            end
            n_checks++;
            if (trig_any_o !== (|e.mask)) begin
                n_fail++;
                $display("FAIL trig_any_o @%0d: got %b expected %b", cyc, trig_any_o, |e.mask);
            end
        end else if (trig_o !== 4'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected trig_o @%0d: got %b expected 0000", cyc, trig_o);
        end
    endtask

    task automatic step_to(input int unsigned t);
        while (cyc < t) advance();
    endtask

    function automatic int unsigned nth_tick(input int unsigned after, input int unsigned n);
        int unsigned cnt = 0;
        for (int unsigned k = after + 1; k < after + 2000; k++) begin
            if (k % 10 == 1) begin
                cnt++;
                if (cnt == n) return k;
            end
        end
        return 0;
    endfunction

    task automatic test_reset();
        int unsigned t0;
        rst_n_i = 1'b0; trig_i = 4'hF; enable_i = 4'hF; holdoff_i = 8'd1;
        repeat (10) advance();
        n_checks++; if (trig_o !== 4'h0)     begin n_fail++; $display("FAIL reset trig_o: got %b expected 0000", trig_o); end
        n_checks++; if (trig_any_o !== 1'b0) begin n_fail++; $display("FAIL reset trig_any_o: got %b expected 0", trig_any_o); end
        n_checks++; if (busy_o !== 4'h0)     begin n_fail++; $display("FAIL reset busy_o: got %b expected 0000", busy_o); end
        n_checks++; if (reject_o !== 4'h0)   begin n_fail++; $display("FAIL reset reject_o: got %b expected 0000", reject_o); end
        rst_n_i = 1'b1;
        t0 = cyc;
        exp_q.push_back('{t0 + 4, 4'hF});
        step_to(t0 + 4);
        n_checks++; if (busy_o !== 4'hF) begin n_fail++; $display("FAIL release busy_o: got %b expected 1111", busy_o); end
        repeat (300) if (busy_o != 4'h0) advance();
        n_checks++; if (busy_o !== 4'h0) begin n_fail++; $display("FAIL reset idle timeout: busy_o %b expected 0000", busy_o); end
        trig_i = 4'h0;
        repeat (4) advance();
    endtask

    task automatic test_latency_holdoff();
        int unsigned t0, tend, r0;
        holdoff_i = 8'd3;
        r0 = rej_seen[0];
        t0 = cyc;
        trig_i[0] = 1'b1;
        exp_q.push_back('{t0 + 4, 4'b0001});
        advance(); advance();
        trig_i[0] = 1'b0;
        step_to(t0 + 4);
        n_checks++; if (busy_o !== 4'b0001) begin n_fail++; $display("FAIL fire busy_o: got %b expected 0001", busy_o); end
        tend = nth_tick(t0 + 5, 3);
        step_to(tend - 3);
        trig_i[0] = 1'b1;
        exp_q.push_back('{tend + 1, 4'b0001});
        step_to(tend - 1);
        n_checks++; if (busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL holdoff busy before end: got %b expected 1", busy_o[0]); end
        step_to(tend);
        n_checks++; if (busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL holdoff busy at end: got %b expected 0", busy_o[0]); end
        step_to(tend + 1);
        n_checks++; if (busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL reaccept busy: got %b expected 1", busy_o[0]); end
        trig_i[0] = 1'b0;
        repeat (300) if (busy_o != 4'h0) advance();
        n_checks++; if (busy_o !== 4'h0) begin n_fail++; $display("FAIL latency idle timeout: busy_o %b expected 0000", busy_o); end
        n_checks++; if (rej_seen[0] - r0 != 0) begin n_fail++; $display("FAIL latency rejects: got %0d expected 0", rej_seen[0] - r0); end
    endtask

    task automatic test_reject();
        int unsigned t0, tend, r0;
        holdoff_i = 8'd5;
        r0 = rej_seen[1];
        t0 = cyc;
        trig_i[1] = 1'b1;
        exp_q.push_back('{t0 + 4, 4'b0010});
        advance(); advance();
        trig_i[1] = 1'b0;
        step_to(t0 + 20);
        trig_i[1] = 1'b1;
        advance(); advance();
        trig_i[1] = 1'b0;
`ifdef EXT_TRIG_RETRIGGER_EN
        tend = nth_tick(t0 + 24, 5);
`else
        tend = nth_tick(t0 + 5, 5);
`endif
        step_to(tend - 1);
        n_checks++; if (busy_o[1] !== 1'b1) begin n_fail++; $display("FAIL reject busy before end: got %b expected 1", busy_o[1]); end
        step_to(tend);
        n_checks++; if (busy_o[1] !== 1'b0) begin n_fail++; $display("FAIL reject busy at end: got %b expected 0", busy_o[1]); end
        n_checks++; if (rej_seen[1] - r0 != 1) begin n_fail++; $display("FAIL reject count: got %0d expected 1", rej_seen[1] - r0); end
    endtask

    task automatic test_zero_holdoff();
        int unsigned t0, r0;
        holdoff_i = 8'd0;
        r0 = rej_seen[2];
        t0 = cyc;
        for (int unsigned k = 0; k < 6; k++) begin
            step_to(t0 + 3 * k);
            trig_i[2] = 1'b1;
            exp_q.push_back('{t0 + 3 * k + 4, 4'b0100});
            advance();
            trig_i[2] = 1'b0;
        end
        step_to(t0 + 3 * 6 + 5);
        n_checks++; if (rej_seen[2] - r0 != 0) begin n_fail++; $display("FAIL zero holdoff rejects: got %0d expected 0", rej_seen[2] - r0); end
        n_checks++; if (busy_o !== 4'h0) begin n_fail++; $display("FAIL zero holdoff busy_o: got %b expected 0000", busy_o); end
    endtask

    task automatic test_enable_independence();
        int unsigned t0, r0;
        holdoff_i = 8'd2;
        enable_i  = 4'b0101;
        r0 = rej_seen[0] + rej_seen[1] + rej_seen[2] + rej_seen[3];
        t0 = cyc;
        trig_i = 4'hF;
        exp_q.push_back('{t0 + 4, 4'b0101});
        advance(); advance();
        trig_i = 4'h0;
        step_to(t0 + 4);
        n_checks++; if (busy_o !== 4'b0101) begin n_fail++; $display("FAIL enable busy_o: got %b expected 0101", busy_o); end
        repeat (300) if (busy_o != 4'h0) advance();
        n_checks++; if (busy_o !== 4'h0) begin n_fail++; $display("FAIL enable idle timeout: busy_o %b expected 0000", busy_o); end
        n_checks++;
        if (rej_seen[0] + rej_seen[1] + rej_seen[2] + rej_seen[3] - r0 != 0) begin
            n_fail++;
            $display("FAIL enable rejects: got %0d expected 0", rej_seen[0] + rej_seen[1] + rej_seen[2] + rej_seen[3] - r0);
        end
        enable_i = 4'hF;
    endtask

    task automatic test_midop();
        int unsigned t0, t1, tend;
        holdoff_i = 8'd2;
        t0 = cyc;
        trig_i[3] = 1'b1;
        exp_q.push_back('{t0 + 4, 4'b1000});
        advance(); advance();
        trig_i[3] = 1'b0;
        step_to(t0 + 6);
        holdoff_i = 8'd9;
        tend = nth_tick(t0 + 5, 2);
        step_to(tend - 1);
        n_checks++; if (busy_o[3] !== 1'b1) begin n_fail++; $display("FAIL cfg busy before end: got %b expected 1", busy_o[3]); end
        step_to(tend);
        n_checks++; if (busy_o[3] !== 1'b0) begin n_fail++; $display("FAIL cfg busy at end: got %b expected 0", busy_o[3]); end
        advance();
        t1 = cyc;
        trig_i[3] = 1'b1;
        exp_q.push_back('{t1 + 4, 4'b1000});
        advance(); advance();
        trig_i[3] = 1'b0;
        step_to(t1 + 8);
        n_checks++; if (busy_o[3] !== 1'b1) begin n_fail++; $display("FAIL midhold busy: got %b expected 1", busy_o[3]); end
        rst_n_i = 1'b0;
        advance();
        n_checks++; if (busy_o !== 4'h0) begin n_fail++; $display("FAIL midhold reset busy_o: got %b expected 0000", busy_o); end
        rst_n_i = 1'b1;
        repeat (3) advance();
        n_checks++; if (busy_o !== 4'h0) begin n_fail++; $display("FAIL post reset busy_o: got %b expected 0000", busy_o); end
    endtask

    initial begin
        rst_n_i = 1'b0; micro_ce_i = 1'b0; trig_i = 4'h0; enable_i = 4'hF; holdoff_i = 8'd0;
        test_reset();
        test_latency_holdoff();
        test_reject();
        test_zero_holdoff();
        test_enable_independence();
        test_midop();
        repeat (6) advance();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
